// File: rtl/button_conditioner.sv
// button_conditioner: synchronise and debounce a raw pushbutton, emit press/release/long strobes
//   clk           system clock
//   reset         asynchronous, active-high reset
//   btn_raw       raw button, asynchronous to clk, 1 = pressed
//   btn_level     debounced button level
//   press_pulse   one-cycle strobe in the first cycle btn_level is high
//   release_pulse one-cycle strobe in the first cycle btn_level is low
//   long_pulse    one-cycle strobe after LONG_CYCLES cycles of stable press
//   held          high from long_pulse until btn_level falls
module button_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 655,
   parameter int LONG_CYCLES     = 65536,
   parameter int CNT_W           = 17
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic held
);
   typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;
   localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES - 1);
   logic [SYNC_STAGES-1:0] sync;
   logic [CNT_W-1:0] deb_cnt, hold_cnt;
   state_t state;
   logic sync_q, differ, accept, rise, fall;
   assign sync_q = sync[SYNC_STAGES-1];
   assign differ = sync_q != btn_level;
   assign accept = differ && deb_cnt == DEB_MAX;
   assign rise   = accept && sync_q;
   assign fall   = accept && !sync_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync          <= '0;
         deb_cnt       <= '0;
         hold_cnt      <= '0;
         state         <= IDLE;
         btn_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         held          <= 1'b0;
      end else begin
         sync          <= {sync[SYNC_STAGES-2:0], btn_raw};
         deb_cnt       <= (!differ || accept) ? '0 : deb_cnt + 1'b1;
         btn_level     <= accept ? sync_q : btn_level;
         press_pulse   <= rise;
         release_pulse <= fall;
         long_pulse    <= 1'b0;
         // a release edge always wins over the long-press threshold in the same cycle
         case (state)
            IDLE: if (rise) begin
               state    <= PRESSED;
               hold_cnt <= '0;
            end
            PRESSED: if (fall) begin
               state    <= IDLE;
               hold_cnt <= '0;
            end else if (hold_cnt == LONG_MAX) begin
               state      <= LONG;
               long_pulse <= 1'b1;
               held       <= 1'b1;
            end else hold_cnt <= hold_cnt + 1'b1;
            LONG: if (fall) begin
               state    <= IDLE;
               held     <= 1'b0;
               hold_cnt <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
